// File: rtl/mmm_pkg.sv
// Shared entry type, FIFO depth and shift/round/saturate arithmetic for mmm_out_requant.
// Optional macro MMM_RELU_EN clamps negative rounded values to zero before saturation.
package mmm_pkg;

  localparam int ENTRY_QW   = 12;
  localparam int FIFO_DEPTH = 3;

  typedef struct packed {
    logic [ENTRY_QW-1:0] data;
    logic                row_end;
    logic                mat_end;
    logic                sat;
  } fifo_entry_t;

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (ENTRY_QW - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (ENTRY_QW - 1));

  // x arrives sign-extended; 64 bits covers the OUTW+1 intermediate without overflow.
  function automatic fifo_entry_t sat_round(input logic signed [63:0] x,
                                            input logic [7:0]         sh);
    logic signed [63:0] v;
    fifo_entry_t        r;
    r = '0;
    if (sh == 8'd0) v = x;
    else            v = (x + (64'sd1 <<< (sh - 8'd1))) >>> sh;
`ifdef MMM_RELU_EN
    if (v < 64'sd0) v = '0;
`endif
    if (v > SAT_MAX) begin
      r.data = ENTRY_QW'(SAT_MAX);
      r.sat  = 1'b1;
    end else if (v < SAT_MIN) begin
      r.data = ENTRY_QW'(SAT_MIN);
      r.sat  = 1'b1;
    end else begin
      r.data = v[ENTRY_QW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmm_skid_fifo.sv
// Small shift-register FIFO; entry 0 is always the head, and it keeps its
// last value when the FIFO drains so the outputs hold steady while idle.
module mmm_skid_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 3,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [W-1:0]    din,
  input  logic            pop,
  output logic [W-1:0]    head,
  output logic [CNTW-1:0] count
);

  logic [W-1:0]    mem   [DEPTH];
  logic [W-1:0]    mem_n [DEPTH];
  logic [CNTW-1:0] count_n;
  logic [CNTW-1:0] wr_idx;
  logic            pop_ok;
  logic            push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CNTW'(DEPTH)) || pop_ok);
  assign wr_idx  = pop_ok ? count - CNTW'(1) : count;

  always_comb begin
    // NOTE: every comb output gets a full default first so no latch is inferred.
    mem_n   = mem;
    count_n = count;
    if (pop_ok) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if ((i + 1) < int'(count)) mem_n[i] = mem[i + 1];
      end
    end
    if (push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(wr_idx)) mem_n[i] = din;
      end
    end
    case ({push_ok, pop_ok})
      2'b10:   count_n = count + CNTW'(1);
      2'b01:   count_n = count - CNTW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      // NOTE: storage is reset because the head entry drives output ports directly.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= count_n;
      mem   <= mem_n;
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/mmm_out_requant.sv
// Requantizes the MMM result stream: per-matrix rounding right shift, saturation to QW
// bits, row/matrix framing. Optional macro MMM_RELU_EN (see mmm_pkg) adds a ReLU clamp.
module mmm_out_requant
  import mmm_pkg::*;
#(
  parameter  int OUTW    = 32,
  parameter  int QW      = ENTRY_QW,
  parameter  int M       = 7,
  parameter  int N       = 9,
  localparam int SH_BITS = $clog2(OUTW)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OUTW-1:0]    IN_TDATA,
  input  logic               IN_TVALID,
  output logic               IN_TREADY,
  input  logic [SH_BITS-1:0] SHIFT,
  output logic [QW-1:0]      OUT_TDATA,
  output logic               OUT_TVALID,
  input  logic               OUT_TREADY,
  output logic               OUT_TUSER,
  output logic               OUT_TLAST,
  output logic               SAT_FLAG
);

  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int RW   = (M > 1) ? $clog2(M) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [SH_BITS-1:0] sh_reg;
  logic [SH_BITS-1:0] sh_eff;
  logic               s1_valid;
  fifo_entry_t        s1;
  fifo_entry_t        s1_n;
  fifo_entry_t        head;
  logic [CNTW-1:0]    fifo_count;
  logic [CNTW:0]      occupancy;
  logic               sat_flag;
  logic               accept;
  logic               first;
  logic               row_end;
  logic               mat_end;
  logic               push;
  logic               pop;

  assign first   = (col == '0) && (row == '0);
  assign row_end = (col == COL_LAST);
  assign mat_end = row_end && (row == ROW_LAST);
  assign sh_eff  = first ? SHIFT : sh_reg;

  // Ready depends only on registered occupancy, never on OUT_TREADY.
  assign occupancy = (CNTW + 1)'(s1_valid) + (CNTW + 1)'(fifo_count);
  assign IN_TREADY = !reset && (occupancy < (CNTW + 1)'(FIFO_DEPTH));
  assign accept    = IN_TVALID && IN_TREADY;

  assign pop  = OUT_TVALID && OUT_TREADY;
  assign push = s1_valid && ((fifo_count != CNTW'(FIFO_DEPTH)) || pop);

  always_comb begin
    s1_n         = sat_round(64'(signed'(IN_TDATA)), 8'(sh_eff));
    s1_n.row_end = row_end;
    s1_n.mat_end = mat_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      sh_reg   <= '0;
      s1_valid <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        if (row_end) begin
          col <= '0;
          row <= mat_end ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (first) begin
          sh_reg   <= SHIFT;
          sat_flag <= s1_n.sat;
        end else begin
          sat_flag <= sat_flag | s1_n.sat;
        end
      end else if (push) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // NOTE: the S1 payload carries no reset; s1_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (accept) s1 <= s1_n;
  end

  mmm_skid_fifo #(
    .W     ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (s1),
    .pop   (pop),
    .head  (head),
    .count (fifo_count)
  );

  assign OUT_TVALID = (fifo_count != '0);
  assign OUT_TDATA  = head.data;
  assign OUT_TUSER  = head.row_end;
  assign OUT_TLAST  = head.mat_end;
  assign SAT_FLAG   = sat_flag;

endmodule

// File: tb/tb_mmm_out_requant.sv
// Directed bench for mmm_out_requant with a scoreboard queue and a cycle-level model.
module tb_mmm_out_requant;

  localparam int OUTW    = 32;
  localparam int QW      = 12;
  localparam int M       = 7;
  localparam int N       = 9;
  localparam int SH_BITS = $clog2(OUTW);

  logic               clk = 1'b0;
  logic               reset;
  logic [OUTW-1:0]    IN_TDATA;
  logic               IN_TVALID;
  logic               IN_TREADY;
  logic [SH_BITS-1:0] SHIFT;
  logic [QW-1:0]      OUT_TDATA;
  logic               OUT_TVALID;
  logic               OUT_TREADY;
  logic               OUT_TUSER;
  logic               OUT_TLAST;
  logic               SAT_FLAG;

  always #5 clk = ~clk;

  mmm_out_requant #(.OUTW(OUTW), .QW(QW), .M(M), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .IN_TDATA   (IN_TDATA),
    .IN_TVALID  (IN_TVALID),
    .IN_TREADY  (IN_TREADY),
    .SHIFT      (SHIFT),
    .OUT_TDATA  (OUT_TDATA),
    .OUT_TVALID (OUT_TVALID),
    .OUT_TREADY (OUT_TREADY),
    .OUT_TUSER  (OUT_TUSER),
    .OUT_TLAST  (OUT_TLAST),
    .SAT_FLAG   (SAT_FLAG)
  );

  typedef struct {
    longint d;
    bit     u;
    bit     l;
    int     c;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall_left = 0;
  int          low_run = 0;
  int          m_col = 0;
  int          m_row = 0;
  int          m_sh = 0;
  bit          sat_exp = 1'b0;
  bit          chk_lat = 1'b0;
  bit          hold_prev = 1'b0;
  bit          acc_flag = 1'b0;
  logic        sat_at_last = 1'b0;
  logic [QW-1:0] held_d;
  logic        held_u;
  logic        held_l;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference arithmetic: round half toward +inf, optional ReLU, clip to QW bits.
  function automatic void model(input longint x, input int sh, output longint d, output bit s);
    longint v;
    longint hi;
    longint lo;
    hi = (longint'(1) << (QW - 1)) - 1;
    lo = -(longint'(1) << (QW - 1));
    if (sh == 0) v = x;
    else         v = (x + (longint'(1) << (sh - 1))) >>> sh;
`ifdef MMM_RELU_EN
    if (v < 0) v = 0;
`endif
    s = 1'b0;
    d = v;
    if (v > hi) begin d = hi; s = 1'b1; end
    else if (v < lo) begin d = lo; s = 1'b1; end
  endfunction

  task automatic cycle();
    exp_t   e;
    longint d;
    bit     s;
    bit     first;
    int     sh;
    @(negedge clk);
    check("sat_flag", SAT_FLAG, sat_exp);
    low_run = OUT_TREADY ? 0 : low_run + 1;
    if (low_run == 10) begin
      check("in_ready_full", IN_TREADY, 0);
      check("out_valid_full", OUT_TVALID, 1);
    end
    if (hold_prev) begin
      check("hold_valid", OUT_TVALID, 1);
      check("hold_data", OUT_TDATA, held_d);
      check("hold_user", OUT_TUSER, held_u);
      check("hold_last", OUT_TLAST, held_l);
    end
    hold_prev = OUT_TVALID && !OUT_TREADY;
    held_d = OUT_TDATA;
    held_u = OUT_TUSER;
    held_l = OUT_TLAST;
    if (OUT_TVALID && OUT_TREADY) begin
      if (q.size() == 0) begin
        check("spurious_out", OUT_TVALID, 0);
      end else begin
        e = q.pop_front();
        check("out_data", 64'(signed'(OUT_TDATA)), e.d);
        check("out_user", OUT_TUSER, e.u);
        check("out_last", OUT_TLAST, e.l);
        if (chk_lat) check("latency", cyc - e.c, 2);
        if (OUT_TLAST) sat_at_last = SAT_FLAG;
      end
    end
    acc_flag = IN_TVALID && IN_TREADY;
    if (acc_flag) begin
      first = (m_col == 0) && (m_row == 0);
      sh = first ? int'(SHIFT) : m_sh;
      m_sh = sh;
      model(longint'(signed'(IN_TDATA)), sh, d, s);
      sat_exp = first ? s : (sat_exp | s);
      e.d = d;
      e.u = (m_col == N - 1);
      e.l = e.u && (m_row == M - 1);
      e.c = cyc;
      q.push_back(e);
      if (m_col == N - 1) begin
        m_col = 0;
        m_row = (m_row == M - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (stall_left > 0) begin
      OUT_TREADY = 1'b0;
      stall_left--;
    end else begin
      OUT_TREADY = 1'b1;
    end
  endtask

  task automatic send(input int x, input int sh);
    int n = 0;
    IN_TDATA  = OUTW'(x);
    SHIFT     = SH_BITS'(sh);
    IN_TVALID = 1'b1;
    acc_flag  = 1'b0;
    while (!acc_flag && n < 100) begin
      cycle();
      n++;
    end
    if (!acc_flag) check("accept_timeout", acc_flag, 1);
  endtask

  task automatic drain();
    int n = 0;
    IN_TVALID = 1'b0;
    while (q.size() != 0 && n < 60) begin
      cycle();
      n++;
    end
    check("drain_empty", q.size(), 0);
    @(negedge clk);
    check("valid_drop", OUT_TVALID, 0);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    IN_TVALID  = 1'b0;
    IN_TDATA   = '0;
    SHIFT      = '0;
    OUT_TREADY = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", IN_TREADY, 0);
    check("rst_out_valid", OUT_TVALID, 0);
    check("rst_out_data", OUT_TDATA, 0);
    check("rst_out_user", OUT_TUSER, 0);
    check("rst_out_last", OUT_TLAST, 0);
    check("rst_sat", SAT_FLAG, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", IN_TREADY, 1);
    @(posedge clk);
    cyc++;
    #1;

    // Full matrix, identity shift, full throughput.
    chk_lat = 1'b1;
    for (int i = 0; i < M * N; i++) send(i, 0);
    drain();

    // Rounding with shift 4; SHIFT changes mid-matrix must be ignored.
    send(23, 4);
    send(24, 0);
    send(-24, 0);
    send(-25, 4);
    for (int i = 0; i < M * N - 4; i++) send(16 * i + 3, 0);
    drain();

    // Saturation and the sticky flag.
    send(2047, 0);
    check("sat_after_2047", SAT_FLAG, 0);
    send(2048, 0);
    check("sat_after_2048", SAT_FLAG, 1);
    send(-2048, 0);
    send(-2049, 0);
    for (int i = 0; i < M * N - 4; i++) send(i, 0);
    drain();
    check("sat_at_tlast", sat_at_last, 1);
    send(5, 0);
    check("sat_cleared", SAT_FLAG, 0);

    // Backpressure: output stalled 10 cycles mid-stream.
    chk_lat = 1'b0;
    for (int i = 1; i < M * N; i++) begin
      if (i == 5) stall_left = 10;
      send(200 + i, 0);
    end
    drain();

    // Reset in the middle of a matrix.
    chk_lat = 1'b1;
    for (int i = 0; i < 20; i++) send(300 + i, 0);
    IN_TVALID  = 1'b0;
    OUT_TREADY = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", IN_TREADY, 0);
    @(posedge clk);
    cyc++;
    #1;
    reset      = 1'b0;
    OUT_TREADY = 1'b1;
    q.delete();
    m_col     = 0;
    m_row     = 0;
    sat_exp   = 1'b0;
    hold_prev = 1'b0;
    low_run   = 0;
    @(negedge clk);
    check("mid_rst_idle", OUT_TVALID, 0);
    check("mid_rst_data", OUT_TDATA, 0);
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < M * N; i++) send(400 + i, 0);
    drain();

    // Negative and positive samples (ReLU clamps the negative one when enabled).
    send(-5, 0);
    send(7, 0);
    for (int i = 0; i < M * N - 2; i++) send(i, 0);
    drain();
    check("final_sat", SAT_FLAG, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
